// File: rtl/read_byte_sequencer_pkg.sv
// Shared types and constants for the read_byte_sequencer slice: FSM encoding,
// word/byte geometry and the word-to-byte lane selection.
package read_byte_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam int WORD_W         = 18;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 3;
  localparam int IDX_W          = 2;
  localparam int TOP_BITS       = 2;
  localparam int TOP_PAD        = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  // The final byte carries the two top word bits left-justified, zero padded.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx);
    case (idx)
      2'd0:    return word[BYTE_W-1:0];
      2'd1:    return word[2*BYTE_W-1:BYTE_W];
      default: return {word[WORD_W-1 -: TOP_BITS], {TOP_PAD{1'b0}}};
    endcase
  endfunction

endpackage

// File: rtl/read_byte_sequencer_byte_serializer.sv
// Holds one captured memory word and presents it low byte first on a
// valid/ready byte stream; pulses done when the final byte is accepted.
module byte_serializer
  import read_byte_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              byte_ready,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              done
);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              accept;
  logic              at_last;

  assign accept  = valid_q && byte_ready;
  assign at_last = (idx_q == LAST_IDX);

  // NOTE: the word register is reset along with the control flops so an
  // aborted word can never resurface as stale byte data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      if (at_last) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = valid_q ? word_byte(word_q, idx_q) : '0;
  assign byte_last  = valid_q && at_last;
  assign done       = accept && at_last;

endmodule

// File: rtl/read_byte_sequencer.sv
// Shares one word-memory read port between two round-robin requesters and
// streams each fetched 18-bit word out as three tagged bytes.
module read_byte_sequencer
  import read_byte_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 1    // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_owner,
  input  logic              byte_ready
);

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              owner_q;
  logic              favour1_q;
  logic [1:0]        lat_q;
  logic              idle;
  logic              win0, win1, grant;
  logic              capture;
  logic              ser_done;
  logic              ser_valid;

  // Requester 1 wins when alone, or when both ask and it was not granted last.
  assign idle  = (state_q == IDLE);
  assign win1  = req1_valid && (!req0_valid || favour1_q);
  assign win0  = req0_valid && !win1;
  assign grant = idle && (win0 || win1);

  assign req0_ready = idle && win0;
  assign req1_ready = idle && win1;

  // NOTE: every variable assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lat_q == 2'd0) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND:  if (ser_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      owner_q   <= 1'b0;
      favour1_q <= 1'b0;
      lat_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        addr_q    <= win1 ? req1_addr : req0_addr;
        owner_q   <= win1;
        favour1_q <= win0;
      end
      if (state_q == ISSUE) begin
        lat_q <= LAT_LOAD;
      end else if (state_q == WAIT && lat_q != 2'd0) begin
        lat_q <= lat_q - 2'd1;
      end
    end
  end

  assign mem_re   = (state_q == ISSUE);
  assign mem_addr = mem_re ? addr_q : '0;

  byte_serializer u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (capture),
    .word       (mem_rdata),
    .byte_ready (byte_ready),
    .byte_valid (ser_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .done       (ser_done)
  );

  assign byte_valid = ser_valid;
  assign byte_owner = ser_valid && owner_q;

endmodule

// File: tb/tb_read_byte_sequencer.sv
// Scoreboard bench for read_byte_sequencer: a latency-1 instance for the main
// scenarios and a latency-4 instance for the latency sweep.
module tb_read_byte_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       owner;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [9:0] req0_addr, req1_addr, mem_addr;
  logic       mem_re, byte_valid, byte_last, byte_owner, byte_ready;
  logic [17:0] mem_rdata;
  logic [7:0] byte_data;

  logic       req0_valid_b, req1_valid_b, req0_ready_b, req1_ready_b;
  logic [9:0] req0_addr_b, req1_addr_b, mem_addr_b;
  logic       mem_re_b, byte_valid_b, byte_last_b, byte_owner_b, byte_ready_b;
  logic [17:0] mem_rdata_b;
  logic [7:0] byte_data_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] mem [0:1023];
  beat_t sb_q[$];
  int    grant_owner[$];
  int    grant_cyc[$];

  read_byte_sequencer #(.ADDR_W(10), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_owner(byte_owner), .byte_ready(byte_ready)
  );

  read_byte_sequencer #(.ADDR_W(10), .MEM_LATENCY(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid_b), .req0_addr(req0_addr_b), .req0_ready(req0_ready_b),
    .req1_valid(req1_valid_b), .req1_addr(req1_addr_b), .req1_ready(req1_ready_b),
    .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .byte_valid(byte_valid_b), .byte_data(byte_data_b), .byte_last(byte_last_b),
    .byte_owner(byte_owner_b), .byte_ready(byte_ready_b)
  );

  // Memory models: data is only meaningful exactly MEM_LATENCY cycles after mem_re.
  logic       v1 = 1'b0;
  logic [9:0] a1 = '0;
  always @(posedge clk) begin
    v1 <= mem_re;
    a1 <= mem_addr;
  end
  assign mem_rdata = v1 ? mem[a1] : 18'h15555;

  logic [3:0] vb = '0;
  logic [9:0] ab [4];
  always @(posedge clk) begin
    vb    <= {vb[2:0], mem_re_b};
    ab[0] <= mem_addr_b;
    for (int i = 1; i < 4; i++) ab[i] <= ab[i-1];
  end
  assign mem_rdata_b = vb[3] ? mem[ab[3]] : 18'h15555;

  function automatic beat_t beat_of(input logic [17:0] w, input int k, input logic own);
    beat_t b;
    b.owner = own;
    b.last  = (k == 2);
    if (k == 0)      b.data = w[7:0];
    else if (k == 1) b.data = w[15:8];
    else             b.data = {w[17:16], 6'b000000};
    return b;
  endfunction

  task automatic push_word(input logic [17:0] w, input logic own);
    for (int k = 0; k < 3; k++) sb_q.push_back(beat_of(w, k, own));
  endtask

  // Grant logger / expected-byte producer and byte scoreboard for the latency-1 DUT.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready || req1_ready) begin
        checks++;
        if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) || (req1_ready && !req1_valid)) begin
          errors++;
          $display("FAIL grant_legal: ready0=%b ready1=%b valid0=%b valid1=%b", req0_ready, req1_ready, req0_valid, req1_valid);
        end
        if (req0_ready) begin
          grant_owner.push_back(0);
          grant_cyc.push_back(cyc);
          push_word(mem[req0_addr], 1'b0);
        end else begin
          grant_owner.push_back(1);
          grant_cyc.push_back(cyc);
          push_word(mem[req1_addr], 1'b1);
        end
      end
      if (byte_valid && byte_ready) begin
        beat_t want;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected: got data=%h last=%b owner=%b, none expected", byte_data, byte_last, byte_owner);
        end else begin
          want = sb_q.pop_front();
          if ({byte_data, byte_last, byte_owner} !== want) begin
            errors++;
            $display("FAIL byte: got data=%h last=%b owner=%b, want data=%h last=%b owner=%b",
                     byte_data, byte_last, byte_owner, want.data, want.last, want.owner);
          end
        end
      end
    end
  end

  // Requesters must hold their address while waiting for a grant.
  logic       pend0 = 1'b0, pend1 = 1'b0;
  logic [9:0] hold0 = '0, hold1 = '0;
  always @(negedge clk) begin
    if (rst_n && pend0 && req0_valid)
      assert (req0_addr == hold0) else $error("protocol: req0 address changed while waiting");
    if (rst_n && pend1 && req1_valid)
      assert (req1_addr == hold1) else $error("protocol: req1 address changed while waiting");
    pend0 = rst_n && req0_valid && !req0_ready;
    pend1 = rst_n && req1_valid && !req1_ready;
    hold0 = req0_addr;
    hold1 = req1_addr;
  end

  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0; byte_ready = 0;
    req0_valid_b = 0; req1_valid_b = 0; req0_addr_b = '0; req1_addr_b = '0; byte_ready_b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    grant_owner.delete();
    grant_cyc.delete();
  endtask

  task automatic request(input int idx, input logic [9:0] addr);
    int n;
    logic got;
    @(posedge clk); #1;
    if (idx == 0) begin req0_valid = 1; req0_addr = addr; end
    else          begin req1_valid = 1; req1_addr = addr; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = (idx == 0) ? req0_ready : req1_ready;
    end while (!got && n < 30);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL request_accept: requester %0d not accepted within %0d cycles, want accept", idx, n);
    end
    @(posedge clk); #1;
    if (idx == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb_q.size() != 0 || byte_valid) && n < 60);
    checks++;
    if (sb_q.size() != 0 || byte_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding valid=%b, want 0 and valid=0", name, sb_q.size(), byte_valid);
    end
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    apply_reset();
    @(negedge clk);
    outs = {req0_ready, req1_ready, mem_re, mem_addr, byte_valid, byte_data, byte_last, byte_owner};
    checks++;
    if (outs !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs_l1: got %h, want 000000", outs);
    end
    outs = {req0_ready_b, req1_ready_b, mem_re_b, mem_addr_b, byte_valid_b, byte_data_b, byte_last_b, byte_owner_b};
    checks++;
    if (outs !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs_l4: got %h, want 000000", outs);
    end
  endtask

  task automatic test_single();
    mem[10'h005] = 18'h2A5C3;
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_addr = 10'h005;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b, want 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 10'h005) begin
      errors++;
      $display("FAIL single_issue: got re=%b addr=%h, want re=1 addr=005", mem_re, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b0 || mem_addr !== 10'h000 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got re=%b addr=%h valid=%b, want 0 000 0", mem_re, mem_addr, byte_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (byte_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_valid%0d: got %b, want 1", k, byte_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_end: got valid=%b pending=%0d, want 0 0", byte_valid, sb_q.size());
    end
  endtask

  task automatic test_contention();
    int n = 0;
    apply_reset();
    mem[10'h010] = 18'h0F1E2;
    mem[10'h020] = 18'h3C3D4;
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_addr = 10'h010;
    req1_valid = 1; req1_addr = 10'h020;
    do begin @(negedge clk); n++; end while (grant_owner.size() < 4 && n < 100);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (grant_owner.size() < 4) begin
      errors++;
      $display("FAIL contention_grants: got %0d grants, want 4", grant_owner.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_owner[i] != i % 2) begin
          errors++;
          $display("FAIL contention_order%0d: got owner %0d, want %0d", i, grant_owner[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (grant_cyc[i] - grant_cyc[i-1] != 6) begin
          errors++;
          $display("FAIL contention_gap%0d: got %0d cycles, want 6", i, grant_cyc[i] - grant_cyc[i-1]);
        end
      end
    end
    wait_drain("contention");
  endtask

  task automatic test_backpressure();
    int n = 0;
    mem[10'h033] = 18'h1FF00;
    byte_ready = 1;
    request(0, 10'h033);
    while (!byte_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h00) begin
      errors++;
      $display("FAIL bp_byte0: got valid=%b data=%h, want 1 00", byte_valid, byte_data);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      byte_ready = (k >= 2);
      @(negedge clk);
      checks++;
      if (k < 3 && {byte_valid, byte_data, byte_last, byte_owner} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b, want 1 ff 0", k, byte_valid, byte_data, byte_last);
      end
      if (k == 3 && {byte_valid, byte_data, byte_last, byte_owner} !== {1'b1, 8'h40, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_byte2: got valid=%b data=%h last=%b, want 1 40 1", byte_valid, byte_data, byte_last);
      end
    end
    wait_drain("backpressure");
  endtask

  task automatic test_latency4();
    int c;
    int n = 0;
    logic [7:0] want [3];
    want[0] = 8'h34; want[1] = 8'h12; want[2] = 8'hC0;
    mem[10'h044] = 18'h31234;
    byte_ready_b = 1;
    @(posedge clk); #1;
    req0_valid_b = 1; req0_addr_b = 10'h044;
    @(negedge clk);
    checks++;
    if (req0_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL lat4_ready: got %b, want 1", req0_ready_b);
    end
    @(posedge clk); #1;
    req0_valid_b = 0;
    @(negedge clk);
    checks++;
    if (mem_re_b !== 1'b1 || mem_addr_b !== 10'h044) begin
      errors++;
      $display("FAIL lat4_issue: got re=%b addr=%h, want 1 044", mem_re_b, mem_addr_b);
    end
    c = cyc;
    do begin @(negedge clk); n++; end while (!byte_valid_b && n < 20);
    checks++;
    if (cyc - c != 5) begin
      errors++;
      $display("FAIL lat4_delay: got first byte %0d cycles after mem_re, want 5", cyc - c);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({byte_valid_b, byte_data_b, byte_last_b, byte_owner_b} !== {1'b1, want[k], k == 2, 1'b0}) begin
        errors++;
        $display("FAIL lat4_byte%0d: got valid=%b data=%h last=%b owner=%b, want 1 %h %b 0",
                 k, byte_valid_b, byte_data_b, byte_last_b, byte_owner_b, want[k], k == 2);
      end
    end
    @(negedge clk);
    checks++;
    if (byte_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL lat4_end: got valid=%b, want 0", byte_valid_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] outs;
    logic        seen;
    int          n = 0;
    mem[10'h055] = 18'h2BEEF;
    byte_ready = 1;
    request(0, 10'h055);
    while (!byte_valid && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    outs = {req0_ready, req1_ready, mem_re, mem_addr, byte_valid, byte_data, byte_last, byte_owner};
    checks++;
    if (outs !== 24'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, want 000000", outs);
    end
    sb_q.delete();
    grant_owner.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (byte_valid || mem_re || req0_ready || req1_ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_stale: got activity=1 after release, want 0");
    end
    mem[10'h066] = 18'h0ABCD;
    request(1, 10'h066);
    wait_drain("midreset");
    checks++;
    if (grant_owner.size() != 1 || grant_owner[0] != 1) begin
      errors++;
      $display("FAIL midreset_fresh: got %0d grants, want one grant to requester 1", grant_owner.size());
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    grant_owner.delete();
    grant_cyc.delete();
    mem[10'h077] = 18'h25A96;
    byte_ready = 1;
    @(posedge clk); #1;
    req1_valid = 1; req1_addr = 10'h077;
    do begin @(negedge clk); n++; end while (grant_owner.size() < 3 && n < 100);
    @(posedge clk); #1;
    req1_valid = 0;
    checks++;
    if (grant_owner.size() < 3) begin
      errors++;
      $display("FAIL b2b_grants: got %0d grants, want 3", grant_owner.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (grant_owner[i] != 1 || grant_cyc[i] - grant_cyc[i-1] != 6) begin
          errors++;
          $display("FAIL b2b_grant%0d: got owner %0d gap %0d, want owner 1 gap 6",
                   i, grant_owner[i], grant_cyc[i] - grant_cyc[i-1]);
        end
      end
    end
    wait_drain("b2b");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 18'(i * 37 + 11);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_latency4();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
